// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_pkg
// Brief    : Shared types, constants and round-robin pick for rr_select_arbiter
// Revision : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Scan last_owner+1 .. last_owner+4 (mod 4); the previous owner is checked last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] last_owner);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last_owner;
        found   = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last_owner + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/grant_decode.sv
`default_nettype none
// ============================================================================
// Module   : grant_decode
// Brief    : 2-to-4 one-hot decode of select, forced to zero without ownership
// Revision : 1.0 - initial release
// ============================================================================
module grant_decode
    import rr_arb_pkg::*;
(
    input  logic [SEL_W-1:0] select,
    input  logic             grant_valid,
    output logic [N_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (grant_valid) begin
            grant[select] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_select_arbiter
// Brief    : Round-robin owner of a shared 2-to-4 select with hold limit and gap
// Revision : 1.0 - initial release
// ============================================================================
module rr_select_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] select,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             timeout,
    output logic             busy
);

    localparam int                c_CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(MAX_HOLD);

    arb_state_t         r_state,      w_state_nxt;
    logic [SEL_W-1:0]   r_select,     w_select_nxt;
    logic [SEL_W-1:0]   r_last_owner, w_last_nxt;
    logic [c_CNT_W-1:0] r_hold_cnt,   w_hold_nxt;
    logic               r_grant_valid, w_valid_nxt;
    logic               r_timeout,    w_timeout_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_select      <= '0;
            r_last_owner  <= SEL_W'(N_REQ - 1);
            r_hold_cnt    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_select      <= w_select_nxt;
            r_last_owner  <= w_last_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_grant_valid <= w_valid_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_select_nxt  = r_select;
        w_last_nxt    = r_last_owner;
        w_hold_nxt    = r_hold_cnt;
        w_valid_nxt   = r_grant_valid;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_select_nxt = rr_pick(req, r_last_owner);
                    w_valid_nxt  = 1'b1;
                    w_hold_nxt   = c_CNT_W'(1);
                    w_state_nxt  = OWN;
                end
            end
            OWN: begin
                // Other request lines are deliberately ignored here: no preemption.
                if (!req[r_select] || (r_hold_cnt == c_MAX)) begin
                    w_valid_nxt   = 1'b0;
                    w_last_nxt    = r_select;
                    w_timeout_nxt = req[r_select];
                    w_state_nxt   = GAP;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_CNT_W'(1);
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    grant_decode u_grant_decode (
        .select      (r_select),
        .grant_valid (r_grant_valid),
        .grant       (grant)
    );

    assign select      = r_select;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rr_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_select_arbiter
// Brief    : Directed table-driven and sequence checks for rr_select_arbiter
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_select_arbiter;

    localparam int MAX_HOLD = 16;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic       valid;
        logic       busy;
        logic       tmo;
        logic [1:0] sel;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] select;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout;
    logic       busy;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic inv_en = 1'b0;
    vec_t vecs[$];

    rr_select_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .select      (select),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then compare every output.
    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic [3:0] g, input logic v, input logic b,
                        input logic t, input logic [1:0] s);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
        chk({tag, " grant"},       {4'b0, grant},       {4'b0, g});
        chk({tag, " grant_valid"}, {7'b0, grant_valid}, {7'b0, v});
        chk({tag, " busy"},        {7'b0, busy},        {7'b0, b});
        chk({tag, " timeout"},     {7'b0, timeout},     {7'b0, t});
        chk({tag, " select"},      {6'b0, select},      {6'b0, s});
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] g,
                                input logic v, input logic b, input logic t,
                                input logic [1:0] s);
        vec_t x;
        x.rst = r; x.req = rq; x.grant = g; x.valid = v; x.busy = b; x.tmo = t; x.sel = s;
        return x;
    endfunction

    always @(negedge clk) begin
        if (inv_en) begin
            n_chk++;
            if (!$onehot0(grant) || (!grant_valid && (grant != 4'b0000))) begin
                n_fail++;
                $display("FAIL invariant: grant=%b grant_valid=%b", grant, grant_valid);
            end
        end
    end

    initial begin
        // basic grant, release, gap, idle from reset
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd0));
        // all request, each owner keeps the grant three cycles
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0));
        for (int k = 0; k < 4; k++) begin
            logic [3:0] rq;
            logic [3:0] oh;
            rq = 4'b1111 << k;
            oh = 4'b0001 << k;
            if (k > 0) begin
                vecs.push_back(mk(0, rq, 4'b0000, 0, 0, 0, 2'(k - 1)));
            end
            for (int c = 0; c < 3; c++) vecs.push_back(mk(0, rq, oh, 1, 1, 0, 2'(k)));
            vecs.push_back(mk(0, rq & ~oh, 4'b0000, 0, 1, 0, 2'(k)));
        end
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd3));
        // owner 2 then 1011: wrap-around order 3, 0, 1
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 1, 0, 2'd2));
        vecs.push_back(mk(0, 4'b1011, 4'b0000, 0, 1, 0, 2'd2));
        vecs.push_back(mk(0, 4'b1011, 4'b0000, 0, 0, 0, 2'd2));
        vecs.push_back(mk(0, 4'b1011, 4'b1000, 1, 1, 0, 2'd3));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 1, 0, 2'd3));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 0, 0, 2'd3));
        vecs.push_back(mk(0, 4'b0011, 4'b0001, 1, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 1, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 1, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd1));
        // reset while owner 1 holds: no gap, priority restarts at req[0]
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 1, 0, 2'd1));
        vecs.push_back(mk(1, 4'b1010, 4'b0000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b1010, 4'b0010, 1, 1, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 2'd1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd1));
        // single-cycle request pulse on bit 3
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 1, 1, 0, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 2'd3));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd3));

        rst = 1'b1;
        @(posedge clk);
        #1;
        inv_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].grant,
                 vecs[i].valid, vecs[i].busy, vecs[i].tmo, vecs[i].sel);
        end

        // forced release after MAX_HOLD cycles, sole requester re-granted
        step("to_rst", 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
        for (int c = 1; c <= MAX_HOLD; c++) begin
            step($sformatf("to_hold%0d", c), 0, 4'b0100, 4'b0100, 1, 1, 0, 2'd2);
        end
        step("to_fire", 0, 4'b0100, 4'b0000, 0, 1, 1, 2'd2);
        step("to_idle", 0, 4'b0100, 4'b0000, 0, 0, 0, 2'd2);
        step("to_regrant", 0, 4'b0100, 4'b0100, 1, 1, 0, 2'd2);
        // competitor arrives mid-hold: ignored until timeout, then wins over owner 2
        for (int c = 2; c <= MAX_HOLD; c++) begin
            step($sformatf("to2_hold%0d", c), 0, 4'b0101, 4'b0100, 1, 1, 0, 2'd2);
        end
        step("to2_fire", 0, 4'b0101, 4'b0000, 0, 1, 1, 2'd2);
        step("to2_idle", 0, 4'b0101, 4'b0000, 0, 0, 0, 2'd2);
        step("to2_next", 0, 4'b0101, 4'b0001, 1, 1, 0, 2'd0);
        step("to2_rel",  0, 4'b0000, 4'b0000, 0, 1, 0, 2'd0);
        step("to2_end",  0, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);

        @(negedge clk);
        inv_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
